wasm_mem_arbiter: RTL and testbench
===================================

WASM_MEM_ARBITER -- requirements
Module: wasm_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, giving the number of CPU-side request ports (P, 1..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the wait-state watchdog limit; it is used only under WASM_ARB_TIMEOUT_EN.
REQ-003 SHALL have ports clk (in, 1), the clock, and rst_n (in, 1), the reset; one clock, with reset asynchronous and active-low.
REQ-004 SHALL have p_rd_en_i (in, P), p_rd_addr_i (in, P×32) and p_rd_op_i (in, P×mem_op_t): per-port load request.
REQ-005 SHALL have p_wr_en_i (in, P), p_wr_addr_i (in, P×32), p_wr_op_i (in, P×mem_op_t) and p_wr_data_i (in, P×64): per-port store request.
REQ-006 SHALL have p_grow_en_i (in, P) and p_grow_pages_i (in, P×32): per-port memory.grow request.
REQ-007 SHALL have p_rd_data_o (out, P×64) and p_rd_valid_o (out, P): per-port load response.
REQ-008 SHALL have p_wr_valid_o (out, P), p_grow_result_o (out, P×32) and p_trap_o (out, P×trap_t): per-port store, grow and trap response.
REQ-009 SHALL have p_busy_o (out, P), meaning the port's request latch is full, and p_overflow_o (out, P), a sticky flag meaning a request was dropped.
REQ-010 SHALL have p_timeout_o (out, P): one-cycle watchdog expiry pulse.
REQ-011 SHALL have current_pages_o (out, 32): page count broadcast to all ports.
REQ-012 SHALL have downstream outputs m_rd_en_o, m_rd_addr_o, m_rd_op_o, m_wr_en_o, m_wr_addr_o, m_wr_op_o, m_wr_data_o, m_grow_en_o and m_grow_pages_o, with the same widths as a single port.
REQ-013 SHALL have downstream inputs m_rd_data_i (64), m_rd_valid_i, m_wr_valid_i, m_current_pages_i (32), m_grow_result_i (32) and m_trap_i (trap_t).

Function
REQ-014 SHALL give each port a one-entry latch that captures a request on any en pulse while the latch is empty; if several enables are high in one cycle, priority is grow > wr > rd, the losers are dropped and p_overflow_o is set.
REQ-015 SHALL drop any request arriving while the latch is full and set p_overflow_o, except on the granted port in its completion cycle, where the latch clears and recaptures with no overflow.
REQ-016 SHALL run the FSM IDLE -> ISSUE -> WAIT -> IDLE; in IDLE it grants the first full latch at or after rr_ptr, wrapping modulo P.
REQ-017 SHALL, in ISSUE, drive exactly one m_*_en_o high for one cycle with the latched fields; all m_* outputs are 0 outside ISSUE.
REQ-018 SHALL complete WAIT on m_rd_valid_i (rd), on m_wr_valid_i (wr), on the first WAIT cycle for grow (sampling m_grow_result_i), or on any op when m_trap_i != TRAP_NONE.
REQ-019 SHALL, on completion, register the response to the granted port only, as a one-cycle pulse of the matching valid or p_trap_o; it then clears the latch, sets rr_ptr = (grant+1) mod P and returns to IDLE.
REQ-020 SHALL hold non-granted port outputs at 0 with p_trap_o = TRAP_NONE.
REQ-021 SHALL meet this latency with the arbiter idle: p_rd_en_i in cycle 0 -> m_rd_en_o in cycle 2; a memory response in cycle 2+L -> p_rd_valid_o in cycle 3+L.
REQ-022 SHALL drive current_pages_o combinationally from m_current_pages_i.
REQ-023 SHALL behave with P=1 as a pass-through with the same latency, and rr_ptr SHALL stay 0.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear all outputs to 0 (p_trap_o to TRAP_NONE), set state IDLE and rr_ptr 0, empty all latches and clear p_overflow_o.
REQ-025 SHALL drop any outstanding operation when reset asserts mid-operation, with no response pulse after release.

Configuration
REQ-026 SHALL, with WASM_ARB_TIMEOUT_EN defined, count WAIT cycles; on reaching TIMEOUT_CYCLES without completion it pulses p_timeout_o[grant] for one cycle, sends no valid, clears the latch, advances rr_ptr and returns to IDLE.
REQ-027 SHALL, without WASM_ARB_TIMEOUT_EN, have no counter, tie p_timeout_o to 0 and let WAIT stay unbounded.

Verification
REQ-028 Single load, P=2, L=1: port0 rd addr 0x100 in cycle 0 -> m_rd_en_o in cycle 2; m_rd_data_i 0xDEAD in cycle 3 -> p_rd_valid_o[0] with 0xDEAD in cycle 4; port1 outputs stay 0.
REQ-029 Contention: both ports issue a wr in the same cycle with rr_ptr 0 -> port0 is served first, then port1; the following simultaneous pair is served port0 first again, since rr_ptr has wrapped to 0.
REQ-030 Overflow: port1 issues rd, then wr while busy -> the wr is dropped, p_overflow_o[1] stays 1 until reset, and the rd still completes.
REQ-031 Trap: m_trap_i = TRAP_MEM_OOB during a port0 load -> p_trap_o[0] = TRAP_MEM_OOB for one cycle, no p_rd_valid_o, and the latch is freed.
REQ-032 Timeout (macro on, TIMEOUT_CYCLES=8): no m_rd_valid_i -> p_timeout_o[0] pulses 8 cycles after entering WAIT, then the next request is granted.
REQ-033 Reset asserted in WAIT -> all outputs 0 immediately; a late m_rd_valid_i after release produces no p_rd_valid_o.

Source files
------------

// File: rtl/wasm_mem_arbiter.sv
// Round-robin arbiter that funnels per-port WebAssembly load/store/grow requests onto one memory port.
// Optional wait-state watchdog enabled by defining WASM_ARB_TIMEOUT_EN.

package wasm_mem_arbiter_pkg;
    typedef logic [3:0] mem_op_t;

    typedef enum logic [2:0] {
        TRAP_NONE      = 3'd0,
        TRAP_MEM_OOB   = 3'd1,
        TRAP_UNALIGNED = 3'd2,
        TRAP_GROW_FAIL = 3'd3
    } trap_t;
endpackage

module wasm_mem_arbiter
    import wasm_mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic    [NUM_PORTS-1:0]        p_rd_en_i,
    input  logic    [NUM_PORTS-1:0][31:0]  p_rd_addr_i,
    input  mem_op_t [NUM_PORTS-1:0]        p_rd_op_i,
    input  logic    [NUM_PORTS-1:0]        p_wr_en_i,
    input  logic    [NUM_PORTS-1:0][31:0]  p_wr_addr_i,
    input  mem_op_t [NUM_PORTS-1:0]        p_wr_op_i,
    input  logic    [NUM_PORTS-1:0][63:0]  p_wr_data_i,
    input  logic    [NUM_PORTS-1:0]        p_grow_en_i,
    input  logic    [NUM_PORTS-1:0][31:0]  p_grow_pages_i,

    output logic    [NUM_PORTS-1:0][63:0]  p_rd_data_o,
    output logic    [NUM_PORTS-1:0]        p_rd_valid_o,
    output logic    [NUM_PORTS-1:0]        p_wr_valid_o,
    output logic    [NUM_PORTS-1:0][31:0]  p_grow_result_o,
    output trap_t   [NUM_PORTS-1:0]        p_trap_o,
    output logic    [NUM_PORTS-1:0]        p_busy_o,
    output logic    [NUM_PORTS-1:0]        p_overflow_o,
    output logic    [NUM_PORTS-1:0]        p_timeout_o,
    output logic    [31:0]                 current_pages_o,

    output logic                           m_rd_en_o,
    output logic    [31:0]                 m_rd_addr_o,
    output mem_op_t                        m_rd_op_o,
    output logic                           m_wr_en_o,
    output logic    [31:0]                 m_wr_addr_o,
    output mem_op_t                        m_wr_op_o,
    output logic    [63:0]                 m_wr_data_o,
    output logic                           m_grow_en_o,
    output logic    [31:0]                 m_grow_pages_o,

    input  logic    [63:0]                 m_rd_data_i,
    input  logic                           m_rd_valid_i,
    input  logic                           m_wr_valid_i,
    input  logic    [31:0]                 m_current_pages_i,
    input  logic    [31:0]                 m_grow_result_i,
    input  trap_t                          m_trap_i
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
    typedef enum logic [1:0] {K_RD, K_WR, K_GROW} kind_t;

    // Grow requests reuse lat_addr to hold the page count.
    logic    [NUM_PORTS-1:0] lat_full;
    kind_t                   lat_kind [NUM_PORTS];
    logic    [31:0]          lat_addr [NUM_PORTS];
    mem_op_t                 lat_op   [NUM_PORTS];
    logic    [63:0]          lat_data [NUM_PORTS];

    state_t                  state;
    logic    [PTR_W-1:0]     rr_ptr;
    logic    [PTR_W-1:0]     grant;
    logic    [PTR_W-1:0]     pick;
    logic    [PTR_W-1:0]     next_ptr;
    logic                    found;
    kind_t                   cur_kind;
    logic                    trap_hit;
    logic                    done;
    logic                    expire;
    logic                    finish;
    logic    [NUM_PORTS-1:0] release_vec;
    logic    [NUM_PORTS-1:0] any_en;
    logic    [NUM_PORTS-1:0] multi_en;

`ifdef WASM_ARB_TIMEOUT_EN
    logic    [31:0]          wait_cnt;
`else
    logic    [31:0]          unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign p_timeout_o        = '0;
`endif

    assign current_pages_o = m_current_pages_i;
    assign p_busy_o        = lat_full;

    // Search the latches starting at rr_ptr so the most recently served port goes last.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = rr_ptr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && lat_full[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        cur_kind = lat_kind[grant];
        trap_hit = (m_trap_i != TRAP_NONE);
        done     = (state == ST_WAIT) &&
                   (trap_hit ||
                    (cur_kind == K_RD && m_rd_valid_i) ||
                    (cur_kind == K_WR && m_wr_valid_i) ||
                    (cur_kind == K_GROW));
`ifdef WASM_ARB_TIMEOUT_EN
        expire   = (state == ST_WAIT) && !done && (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
        expire   = 1'b0;
`endif
        finish   = done || expire;
        next_ptr = (grant == PTR_W'(NUM_PORTS - 1)) ? '0 : grant + PTR_W'(1);
    end

    always_comb begin
        release_vec = '0;
        any_en      = '0;
        multi_en    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            release_vec[i] = finish && (int'(grant) == i);
            any_en[i]      = p_rd_en_i[i] | p_wr_en_i[i] | p_grow_en_i[i];
            multi_en[i]    = (p_rd_en_i[i] & p_wr_en_i[i]) |
                             (p_rd_en_i[i] & p_grow_en_i[i]) |
                             (p_wr_en_i[i] & p_grow_en_i[i]);
        end
    end

    // A latch being released this cycle may take a new request without counting as overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_full     <= '0;
            p_overflow_o <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                lat_kind[i] <= K_RD;
                lat_addr[i] <= '0;
                lat_op[i]   <= '0;
                lat_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (any_en[i] && (!lat_full[i] || release_vec[i])) begin
                    lat_full[i] <= 1'b1;
                    if (p_grow_en_i[i]) begin
                        lat_kind[i] <= K_GROW;
                        lat_addr[i] <= p_grow_pages_i[i];
                        lat_op[i]   <= '0;
                        lat_data[i] <= '0;
                    end else if (p_wr_en_i[i]) begin
                        lat_kind[i] <= K_WR;
                        lat_addr[i] <= p_wr_addr_i[i];
                        lat_op[i]   <= p_wr_op_i[i];
                        lat_data[i] <= p_wr_data_i[i];
                    end else begin
                        lat_kind[i] <= K_RD;
                        lat_addr[i] <= p_rd_addr_i[i];
                        lat_op[i]   <= p_rd_op_i[i];
                        lat_data[i] <= '0;
                    end
                    if (multi_en[i]) p_overflow_o[i] <= 1'b1;
                end else begin
                    if (any_en[i])      p_overflow_o[i] <= 1'b1;
                    if (release_vec[i]) lat_full[i]     <= 1'b0;
                end
            end
        end
    end

    // Arbitration FSM; every downstream and response output is a registered one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            rr_ptr          <= '0;
            grant           <= '0;
            m_rd_en_o       <= 1'b0;
            m_rd_addr_o     <= '0;
            m_rd_op_o       <= '0;
            m_wr_en_o       <= 1'b0;
            m_wr_addr_o     <= '0;
            m_wr_op_o       <= '0;
            m_wr_data_o     <= '0;
            m_grow_en_o     <= 1'b0;
            m_grow_pages_o  <= '0;
            p_rd_data_o     <= '0;
            p_rd_valid_o    <= '0;
            p_wr_valid_o    <= '0;
            p_grow_result_o <= '0;
            for (int i = 0; i < NUM_PORTS; i++) p_trap_o[i] <= TRAP_NONE;
`ifdef WASM_ARB_TIMEOUT_EN
            wait_cnt        <= '0;
            p_timeout_o     <= '0;
`endif
        end else begin
            m_rd_en_o       <= 1'b0;
            m_rd_addr_o     <= '0;
            m_rd_op_o       <= '0;
            m_wr_en_o       <= 1'b0;
            m_wr_addr_o     <= '0;
            m_wr_op_o       <= '0;
            m_wr_data_o     <= '0;
            m_grow_en_o     <= 1'b0;
            m_grow_pages_o  <= '0;
            p_rd_data_o     <= '0;
            p_rd_valid_o    <= '0;
            p_wr_valid_o    <= '0;
            p_grow_result_o <= '0;
            for (int i = 0; i < NUM_PORTS; i++) p_trap_o[i] <= TRAP_NONE;
`ifdef WASM_ARB_TIMEOUT_EN
            p_timeout_o     <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant <= pick;
                        state <= ST_ISSUE;
                        case (lat_kind[pick])
                            K_GROW: begin
                                m_grow_en_o    <= 1'b1;
                                m_grow_pages_o <= lat_addr[pick];
                            end
                            K_WR: begin
                                m_wr_en_o   <= 1'b1;
                                m_wr_addr_o <= lat_addr[pick];
                                m_wr_op_o   <= lat_op[pick];
                                m_wr_data_o <= lat_data[pick];
                            end
                            default: begin
                                m_rd_en_o   <= 1'b1;
                                m_rd_addr_o <= lat_addr[pick];
                                m_rd_op_o   <= lat_op[pick];
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
`ifdef WASM_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (finish) begin
                        state  <= ST_IDLE;
                        rr_ptr <= next_ptr;
                        if (done) begin
                            if (trap_hit) begin
                                p_trap_o[grant] <= m_trap_i;
                            end else begin
                                case (cur_kind)
                                    K_RD: begin
                                        p_rd_valid_o[grant] <= 1'b1;
                                        p_rd_data_o[grant]  <= m_rd_data_i;
                                    end
                                    K_WR:    p_wr_valid_o[grant]    <= 1'b1;
                                    default: p_grow_result_o[grant] <= m_grow_result_i;
                                endcase
                            end
                        end
`ifdef WASM_ARB_TIMEOUT_EN
                        else begin
                            p_timeout_o[grant] <= 1'b1;
                        end
`endif
                    end
`ifdef WASM_ARB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wasm_mem_arbiter.sv
// Directed bench for wasm_mem_arbiter (two ports); covers the watchdog when WASM_ARB_TIMEOUT_EN is defined.

module tb_wasm_mem_arbiter;
    import wasm_mem_arbiter_pkg::*;

    localparam int RD   = 0;
    localparam int WR   = 1;
    localparam int GROW = 2;

    logic                 clk;
    logic                 rst_n;
    logic    [1:0]        p_rd_en_i;
    logic    [1:0][31:0]  p_rd_addr_i;
    mem_op_t [1:0]        p_rd_op_i;
    logic    [1:0]        p_wr_en_i;
    logic    [1:0][31:0]  p_wr_addr_i;
    mem_op_t [1:0]        p_wr_op_i;
    logic    [1:0][63:0]  p_wr_data_i;
    logic    [1:0]        p_grow_en_i;
    logic    [1:0][31:0]  p_grow_pages_i;
    logic    [1:0][63:0]  p_rd_data_o;
    logic    [1:0]        p_rd_valid_o;
    logic    [1:0]        p_wr_valid_o;
    logic    [1:0][31:0]  p_grow_result_o;
    trap_t   [1:0]        p_trap_o;
    logic    [1:0]        p_busy_o;
    logic    [1:0]        p_overflow_o;
    logic    [1:0]        p_timeout_o;
    logic    [31:0]       current_pages_o;
    logic                 m_rd_en_o;
    logic    [31:0]       m_rd_addr_o;
    mem_op_t              m_rd_op_o;
    logic                 m_wr_en_o;
    logic    [31:0]       m_wr_addr_o;
    mem_op_t              m_wr_op_o;
    logic    [63:0]       m_wr_data_o;
    logic                 m_grow_en_o;
    logic    [31:0]       m_grow_pages_o;
    logic    [63:0]       m_rd_data_i;
    logic                 m_rd_valid_i;
    logic                 m_wr_valid_i;
    logic    [31:0]       m_current_pages_i;
    logic    [31:0]       m_grow_result_i;
    trap_t                m_trap_i;

    int checks = 0;
    int errors = 0;

    wasm_mem_arbiter #(.NUM_PORTS(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_rd_en_i(p_rd_en_i), .p_rd_addr_i(p_rd_addr_i), .p_rd_op_i(p_rd_op_i),
        .p_wr_en_i(p_wr_en_i), .p_wr_addr_i(p_wr_addr_i), .p_wr_op_i(p_wr_op_i),
        .p_wr_data_i(p_wr_data_i), .p_grow_en_i(p_grow_en_i), .p_grow_pages_i(p_grow_pages_i),
        .p_rd_data_o(p_rd_data_o), .p_rd_valid_o(p_rd_valid_o), .p_wr_valid_o(p_wr_valid_o),
        .p_grow_result_o(p_grow_result_o), .p_trap_o(p_trap_o), .p_busy_o(p_busy_o),
        .p_overflow_o(p_overflow_o), .p_timeout_o(p_timeout_o), .current_pages_o(current_pages_o),
        .m_rd_en_o(m_rd_en_o), .m_rd_addr_o(m_rd_addr_o), .m_rd_op_o(m_rd_op_o),
        .m_wr_en_o(m_wr_en_o), .m_wr_addr_o(m_wr_addr_o), .m_wr_op_o(m_wr_op_o),
        .m_wr_data_o(m_wr_data_o), .m_grow_en_o(m_grow_en_o), .m_grow_pages_o(m_grow_pages_o),
        .m_rd_data_i(m_rd_data_i), .m_rd_valid_i(m_rd_valid_i), .m_wr_valid_i(m_wr_valid_i),
        .m_current_pages_i(m_current_pages_i), .m_grow_result_i(m_grow_result_i), .m_trap_i(m_trap_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fields: port, kind, addr (pages for grow), op, wdata, latency, mem rdata, mem grow result,
    // mem trap, current pages, then expected {grow,wr,rd} enables, m addr, m op, m wdata,
    // rd_valid vector, wr_valid vector, rd data, grow result, trap.
    typedef struct {
        int          port;
        int          kind;
        logic [31:0] addr;
        logic [3:0]  op;
        logic [63:0] wdata;
        int          lat;
        logic [63:0] mem_rdata;
        logic [31:0] mem_grow;
        trap_t       mem_trap;
        logic [31:0] pages;
        logic [2:0]  exp_m_en;
        logic [31:0] exp_m_addr;
        logic [3:0]  exp_m_op;
        logic [63:0] exp_m_wdata;
        logic [1:0]  exp_rd_valid;
        logic [1:0]  exp_wr_valid;
        logic [63:0] exp_rd_data;
        logic [31:0] exp_grow;
        trap_t       exp_trap;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        p_rd_en_i         = '0;
        p_rd_addr_i       = '0;
        p_rd_op_i         = '0;
        p_wr_en_i         = '0;
        p_wr_addr_i       = '0;
        p_wr_op_i         = '0;
        p_wr_data_i       = '0;
        p_grow_en_i       = '0;
        p_grow_pages_i    = '0;
        m_rd_data_i       = '0;
        m_rd_valid_i      = 1'b0;
        m_wr_valid_i      = 1'b0;
        m_current_pages_i = '0;
        m_grow_result_i   = '0;
        m_trap_i          = TRAP_NONE;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_inputs();
        step_cycle();
        step_cycle();
        rst_n = 1'b1;
        step_cycle();
    endtask

    task automatic wait_issue(input string name);
        int n;
        n = 0;
        while (!(m_rd_en_o | m_wr_en_o | m_grow_en_o) && n < 16) begin
            step_cycle();
            n++;
        end
        checkOutput({name, " issued"}, 64'(m_rd_en_o | m_wr_en_o | m_grow_en_o), 64'd1);
    endtask

    task automatic serve_wr(input string name, input logic [31:0] exp_addr, input logic [1:0] exp_valid);
        wait_issue(name);
        checkOutput({name, " m_wr_addr"}, 64'(m_wr_addr_o), 64'(exp_addr));
        step_cycle();
        m_wr_valid_i = 1'b1;
        step_cycle();
        m_wr_valid_i = 1'b0;
        checkOutput({name, " p_wr_valid"}, 64'(p_wr_valid_o), 64'(exp_valid));
    endtask

    task automatic serve_rd(input string name, input logic [31:0] exp_addr, input logic [63:0] data,
                            input logic [1:0] exp_valid);
        wait_issue(name);
        checkOutput({name, " m_rd_addr"}, 64'(m_rd_addr_o), 64'(exp_addr));
        step_cycle();
        m_rd_valid_i = 1'b1;
        m_rd_data_i  = data;
        step_cycle();
        m_rd_valid_i = 1'b0;
        m_rd_data_i  = '0;
        checkOutput({name, " p_rd_valid"}, 64'(p_rd_valid_o), 64'(exp_valid));
    endtask

    // One isolated transaction: request in cycle 0, issue in cycle 2, response in 2+L, result in 3+L.
    task automatic applyStimulus(input int idx, input vec_t v);
        int    p;
        int    o;
        string tag;
        p   = v.port;
        o   = 1 - v.port;
        tag = $sformatf("vec%0d", idx);
        m_current_pages_i = v.pages;
        case (v.kind)
            RD: begin
                p_rd_en_i[p] = 1'b1; p_rd_addr_i[p] = v.addr; p_rd_op_i[p] = v.op;
            end
            WR: begin
                p_wr_en_i[p] = 1'b1; p_wr_addr_i[p] = v.addr; p_wr_op_i[p] = v.op;
                p_wr_data_i[p] = v.wdata;
            end
            default: begin
                p_grow_en_i[p] = 1'b1; p_grow_pages_i[p] = v.addr;
            end
        endcase
        step_cycle();
        p_rd_en_i = '0; p_wr_en_i = '0; p_grow_en_i = '0;
        checkOutput({tag, " busy"}, 64'(p_busy_o[p]), 64'd1);
        step_cycle();
        checkOutput({tag, " m_en"}, 64'({m_grow_en_o, m_wr_en_o, m_rd_en_o}), 64'(v.exp_m_en));
        checkOutput({tag, " m_addr"}, 64'(m_rd_addr_o | m_wr_addr_o | m_grow_pages_o), 64'(v.exp_m_addr));
        checkOutput({tag, " m_op"}, 64'(m_rd_op_o | m_wr_op_o), 64'(v.exp_m_op));
        checkOutput({tag, " m_wdata"}, m_wr_data_o, v.exp_m_wdata);
        checkOutput({tag, " pages"}, 64'(current_pages_o), 64'(v.pages));
        for (int k = 0; k < v.lat; k++) step_cycle();
        if (v.mem_trap != TRAP_NONE) begin
            m_trap_i = v.mem_trap;
        end else if (v.kind == RD) begin
            m_rd_valid_i = 1'b1; m_rd_data_i = v.mem_rdata;
        end else if (v.kind == WR) begin
            m_wr_valid_i = 1'b1;
        end else begin
            m_grow_result_i = v.mem_grow;
        end
        step_cycle();
        m_trap_i = TRAP_NONE; m_rd_valid_i = 1'b0; m_rd_data_i = '0;
        m_wr_valid_i = 1'b0; m_grow_result_i = '0;
        checkOutput({tag, " rd_valid"}, 64'(p_rd_valid_o), 64'(v.exp_rd_valid));
        checkOutput({tag, " wr_valid"}, 64'(p_wr_valid_o), 64'(v.exp_wr_valid));
        checkOutput({tag, " rd_data"}, p_rd_data_o[p], v.exp_rd_data);
        checkOutput({tag, " grow_result"}, 64'(p_grow_result_o[p]), 64'(v.exp_grow));
        checkOutput({tag, " trap"}, 64'(p_trap_o[p]), 64'(v.exp_trap));
        checkOutput({tag, " other trap"}, 64'(p_trap_o[o]), 64'(TRAP_NONE));
        checkOutput({tag, " other rd_data"}, p_rd_data_o[o], 64'd0);
        step_cycle();
        checkOutput({tag, " pulse end"}, 64'({p_rd_valid_o, p_wr_valid_o, p_trap_o[p]}), 64'd0);
        checkOutput({tag, " busy clear"}, 64'(p_busy_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n;
        logic seen;

        vecs[0] = '{0, RD,   32'h100,   4'h3, 64'h0,                  1, 64'hDEAD,               32'd0,  TRAP_NONE,
                    32'd1, 3'b001, 32'h100,   4'h3, 64'h0,                  2'b01, 2'b00, 64'hDEAD,               32'd0,  TRAP_NONE};
        vecs[1] = '{1, WR,   32'h2000,  4'h7, 64'h1122334455667788,   3, 64'h0,                  32'd0,  TRAP_NONE,
                    32'd2, 3'b010, 32'h2000,  4'h7, 64'h1122334455667788,   2'b00, 2'b10, 64'h0,                  32'd0,  TRAP_NONE};
        vecs[2] = '{0, GROW, 32'd5,     4'h0, 64'h0,                  1, 64'h0,                  32'd17, TRAP_NONE,
                    32'd3, 3'b100, 32'd5,     4'h0, 64'h0,                  2'b00, 2'b00, 64'h0,                  32'd17, TRAP_NONE};
        vecs[3] = '{1, RD,   32'h40,    4'h2, 64'h0,                  2, 64'hCAFEBABE0BADF00D,   32'd0,  TRAP_NONE,
                    32'd4, 3'b001, 32'h40,    4'h2, 64'h0,                  2'b10, 2'b00, 64'hCAFEBABE0BADF00D,   32'd0,  TRAP_NONE};
        vecs[4] = '{0, RD,   32'h10000, 4'h1, 64'h0,                  1, 64'h0,                  32'd0,  TRAP_MEM_OOB,
                    32'd5, 3'b001, 32'h10000, 4'h1, 64'h0,                  2'b00, 2'b00, 64'h0,                  32'd0,  TRAP_MEM_OOB};
        vecs[5] = '{1, WR,   32'h8,     4'h4, 64'h55,                 2, 64'h0,                  32'd0,  TRAP_UNALIGNED,
                    32'd6, 3'b010, 32'h8,     4'h4, 64'h55,                 2'b00, 2'b00, 64'h0,                  32'd0,  TRAP_UNALIGNED};

        clear_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        step_cycle();
        checkOutput("reset busy", 64'(p_busy_o), 64'd0);
        checkOutput("reset overflow", 64'(p_overflow_o), 64'd0);
        checkOutput("reset valids", 64'({p_rd_valid_o, p_wr_valid_o, p_timeout_o}), 64'd0);
        checkOutput("reset m_en", 64'({m_rd_en_o, m_wr_en_o, m_grow_en_o}), 64'd0);
        checkOutput("reset trap", 64'({p_trap_o[1], p_trap_o[0]}), 64'd0);
        step_cycle();
        rst_n = 1'b1;
        step_cycle();

        $display("[TB] directed vector table");
        for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

        $display("[TB] contention");
        reset_dut();
        p_wr_en_i = 2'b11;
        p_wr_addr_i[0] = 32'hA0; p_wr_addr_i[1] = 32'hB0;
        step_cycle();
        p_wr_en_i = '0;
        serve_wr("cont1 first", 32'hA0, 2'b01);
        serve_wr("cont1 second", 32'hB0, 2'b10);
        p_wr_en_i = 2'b11;
        p_wr_addr_i[0] = 32'hC0; p_wr_addr_i[1] = 32'hD0;
        step_cycle();
        p_wr_en_i = '0;
        serve_wr("cont2 first", 32'hC0, 2'b01);
        serve_wr("cont2 second", 32'hD0, 2'b10);
        checkOutput("cont overflow", 64'(p_overflow_o), 64'd0);

        $display("[TB] overflow");
        p_rd_en_i[1] = 1'b1; p_rd_addr_i[1] = 32'h300;
        step_cycle();
        p_rd_en_i = '0;
        p_wr_en_i[1] = 1'b1; p_wr_addr_i[1] = 32'h304;
        step_cycle();
        p_wr_en_i = '0;
        checkOutput("ovf flag set", 64'(p_overflow_o), 64'b10);
        serve_rd("ovf rd", 32'h300, 64'h77, 2'b10);
        checkOutput("ovf rd data", p_rd_data_o[1], 64'h77);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step_cycle();
            if (m_rd_en_o | m_wr_en_o | m_grow_en_o) seen = 1'b1;
        end
        checkOutput("ovf dropped wr not issued", 64'(seen), 64'd0);
        checkOutput("ovf flag sticky", 64'(p_overflow_o), 64'b10);

        $display("[TB] recapture in completion cycle");
        p_rd_en_i[0] = 1'b1; p_rd_addr_i[0] = 32'h400;
        step_cycle();
        p_rd_en_i = '0;
        wait_issue("recap first");
        checkOutput("recap first addr", 64'(m_rd_addr_o), 64'h400);
        step_cycle();
        m_rd_valid_i = 1'b1; m_rd_data_i = 64'h11;
        p_rd_en_i[0] = 1'b1; p_rd_addr_i[0] = 32'h404;
        step_cycle();
        m_rd_valid_i = 1'b0; m_rd_data_i = '0; p_rd_en_i = '0;
        checkOutput("recap rd_valid", 64'(p_rd_valid_o), 64'b01);
        checkOutput("recap busy", 64'(p_busy_o[0]), 64'd1);
        checkOutput("recap no overflow", 64'(p_overflow_o[0]), 64'd0);
        serve_rd("recap second", 32'h404, 64'h22, 2'b01);
        checkOutput("recap second data", p_rd_data_o[0], 64'h22);

        $display("[TB] enable priority");
        p_rd_en_i[0] = 1'b1; p_wr_en_i[0] = 1'b1; p_grow_en_i[0] = 1'b1;
        p_wr_addr_i[0] = 32'h500; p_grow_pages_i[0] = 32'd9;
        step_cycle();
        p_rd_en_i = '0; p_wr_en_i = '0; p_grow_en_i = '0;
        checkOutput("prio overflow", 64'(p_overflow_o[0]), 64'd1);
        wait_issue("prio");
        checkOutput("prio m_en", 64'({m_grow_en_o, m_wr_en_o, m_rd_en_o}), 64'b100);
        checkOutput("prio pages", 64'(m_grow_pages_o), 64'd9);
        step_cycle();
        m_grow_result_i = 32'd10;
        step_cycle();
        m_grow_result_i = '0;
        checkOutput("prio grow result", 64'(p_grow_result_o[0]), 64'd10);
        reset_dut();
        checkOutput("overflow cleared by reset", 64'(p_overflow_o), 64'd0);

        $display("[TB] reset during wait");
        p_rd_en_i[0] = 1'b1; p_rd_addr_i[0] = 32'h600;
        step_cycle();
        p_rd_en_i = '0;
        wait_issue("rstwait");
        step_cycle();
        checkOutput("rstwait busy before", 64'(p_busy_o[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstwait busy async", 64'(p_busy_o), 64'd0);
        checkOutput("rstwait outputs async", 64'({m_rd_en_o, p_rd_valid_o, p_overflow_o}), 64'd0);
        step_cycle();
        rst_n = 1'b1;
        step_cycle();
        m_rd_valid_i = 1'b1; m_rd_data_i = 64'h99;
        step_cycle();
        m_rd_valid_i = 1'b0; m_rd_data_i = '0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (p_rd_valid_o != 2'b00 || m_rd_en_o) seen = 1'b1;
            step_cycle();
        end
        checkOutput("rstwait no late response", 64'(seen), 64'd0);

        $display("[TB] wait-state watchdog");
        p_rd_en_i[0] = 1'b1; p_rd_addr_i[0] = 32'h700;
        step_cycle();
        p_rd_en_i = '0;
        wait_issue("tmo");
        p_rd_en_i[1] = 1'b1; p_rd_addr_i[1] = 32'h710;
        step_cycle();
        p_rd_en_i = '0;
`ifdef WASM_ARB_TIMEOUT_EN
        n = 0;
        seen = 1'b0;
        while (!p_timeout_o[0] && n < 20) begin
            step_cycle();
            n++;
            if (p_rd_valid_o != 2'b00) seen = 1'b1;
        end
        checkOutput("tmo pulse delay", 64'(n), 64'd8);
        checkOutput("tmo no valid", 64'(seen), 64'd0);
        step_cycle();
        checkOutput("tmo one cycle", 64'(p_timeout_o), 64'd0);
        checkOutput("tmo latch freed", 64'(p_busy_o[0]), 64'd0);
        serve_rd("tmo next", 32'h710, 64'h33, 2'b10);
`else
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step_cycle();
            if (p_timeout_o != 2'b00 || p_rd_valid_o != 2'b00) seen = 1'b1;
        end
        checkOutput("no-tmo quiet", 64'(seen), 64'd0);
        checkOutput("no-tmo still busy", 64'(p_busy_o[0]), 64'd1);
        m_rd_valid_i = 1'b1; m_rd_data_i = 64'h44;
        step_cycle();
        m_rd_valid_i = 1'b0; m_rd_data_i = '0;
        checkOutput("no-tmo late valid", 64'(p_rd_valid_o), 64'b01);
        serve_rd("no-tmo next", 32'h710, 64'h33, 2'b10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
